// File: rtl/mux_share_arbiter_pkg.sv
// Shared encodings for the mux_share_arbiter slice: the priority-pointer states and the
// mux select values.
package mux_share_arbiter_pkg;

    localparam logic PRI_A = 1'b0;
    localparam logic PRI_B = 1'b1;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Requester/consumer bundle of mux_share_arbiter; the slave modport is the arbiter's view,
// and the master modport is the view of the requesters and the consumer.
interface mux_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             A_req;
    logic [WIDTH-1:0] A_data;
    logic             A_gnt;
    logic             A_lock;
    logic             B_req;
    logic [WIDTH-1:0] B_data;
    logic             B_gnt;
    logic             B_lock;
    logic             Sel;
    logic             O_valid;
    logic [WIDTH-1:0] O_data;
    logic             O_ready;

    modport slave (
        input  A_req, A_data, A_lock, B_req, B_data, B_lock, O_ready,
        output A_gnt, B_gnt, Sel, O_valid, O_data
    );

    modport master (
        output A_req, A_data, A_lock, B_req, B_data, B_lock, O_ready,
        input  A_gnt, B_gnt, Sel, O_valid, O_data
    );
endinterface

// File: rtl/mux_rr_pick.sv
// Combinational winner logic. An asserted i_x_lock means that X already qualifies to keep
// ownership, so it beats the pointer. Otherwise a tie goes to the pointer side.
module mux_rr_pick
    import mux_share_arbiter_pkg::*;
(
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_ptr,
    input  logic i_a_lock,
    input  logic i_b_lock,
    output logic o_win_vld,
    output logic o_win_b
);
    always_comb begin
        // NOTE: every output gets a default before the branches, so no path infers a latch.
        o_win_vld = 1'b0;
        o_win_b   = 1'b0;
        if (i_a_lock) begin
            o_win_vld = 1'b1;
        end else if (i_b_lock) begin
            o_win_vld = 1'b1;
            o_win_b   = 1'b1;
        end else if (i_a_req && i_b_req) begin
            o_win_vld = 1'b1;
            o_win_b   = (i_ptr == PRI_B);
        end else if (i_a_req) begin
            o_win_vld = 1'b1;
        end else if (i_b_req) begin
            o_win_vld = 1'b1;
            o_win_b   = 1'b1;
        end
    end
endmodule

// File: rtl/mux_share_arbiter_mux2.sv
// Existing WIDTH-bit 2:1 data mux: i_sel=0 passes i_d0 (A), and i_sel=1 passes i_d1 (B).
module mux_share_arbiter_mux2 #(
    parameter int WIDTH = 4
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux with a one-entry valid/ready output register.
// Defining MUX_SHARE_LOCK_EN adds a bounded ownership lock (at most HOLD_MAX grants in a row).
module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    mux_share_arbiter_if.slave   bus
);
    logic             r_ptr;
    logic             r_sel;
    logic             r_o_valid;
    logic [WIDTH-1:0] r_o_data;

    logic             w_load;
    logic             w_win_vld;
    logic             w_win_b;
    logic             w_lock_a;
    logic             w_lock_b;
    logic             w_sel;
    logic             w_a_xfer;
    logic             w_b_xfer;
    logic [WIDTH-1:0] w_mux_data;

    assign w_load = !r_o_valid || bus.O_ready;

`ifdef MUX_SHARE_LOCK_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic             r_last_vld;
    logic             r_last_b;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_hold_full;
    logic             w_locked_xfer;

    // The lock yields only when it has run its course and the other side is waiting.
    assign w_hold_full = (r_hold_cnt >= CNT_W'(HOLD_MAX - 1));
    assign w_lock_a    = r_last_vld && !r_last_b && bus.A_lock && bus.A_req &&
                         !(w_hold_full && bus.B_req);
    assign w_lock_b    = r_last_vld &&  r_last_b && bus.B_lock && bus.B_req &&
                         !(w_hold_full && bus.A_req);
    assign w_locked_xfer = (w_a_xfer && w_lock_a) || (w_b_xfer && w_lock_b);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_vld <= 1'b0;
            r_last_b   <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_a_xfer || w_b_xfer) begin
            r_last_vld <= 1'b1;
            r_last_b   <= w_b_xfer;
            if (!w_locked_xfer)
                r_hold_cnt <= '0;
            else if (!w_hold_full)
                r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_lock_a = 1'b0;
    assign w_lock_b = 1'b0;
`endif

    mux_rr_pick u_pick (
        .i_a_req   (bus.A_req),
        .i_b_req   (bus.B_req),
        .i_ptr     (r_ptr),
        .i_a_lock  (w_lock_a),
        .i_b_lock  (w_lock_b),
        .o_win_vld (w_win_vld),
        .o_win_b   (w_win_b)
    );

    assign w_sel    = w_win_vld ? (w_win_b ? SEL_B : SEL_A) : r_sel;
    assign w_a_xfer = !RST && w_load && w_win_vld && !w_win_b;
    assign w_b_xfer = !RST && w_load && w_win_vld &&  w_win_b;

    mux_share_arbiter_mux2 #(.WIDTH(WIDTH)) u_mux (
        .i_sel (w_sel),
        .i_d0  (bus.A_data),
        .i_d1  (bus.B_data),
        .o_y   (w_mux_data)
    );

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr     <= PRI_A;
            r_sel     <= SEL_A;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
        end else begin
            r_sel <= w_sel;
            if (w_a_xfer || w_b_xfer) begin
                r_o_valid <= 1'b1;
                r_o_data  <= w_mux_data;
            end else if (bus.O_ready) begin
                r_o_valid <= 1'b0;
            end
            if (w_a_xfer)
                r_ptr <= PRI_B;
            else if (w_b_xfer)
                r_ptr <= PRI_A;
        end
    end

    assign bus.A_gnt   = w_a_xfer;
    assign bus.B_gnt   = w_b_xfer;
    assign bus.Sel     = w_sel;
    assign bus.O_valid = r_o_valid;
    assign bus.O_data  = r_o_data;
endmodule
